pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage controller for the five-stage CPU: owns the program counter, issues instruction-memory requests over a req/ack handshake, and buffers one fetched instruction for decode. Applies the same next-PC selection as the single-cycle datapath (sequential, PC+imm, JALR with bit 0 cleared), but only when a redirect is resolved. Handles decode stalls, redirects with an outstanding memory request, and the flush pulse to the IF/ID and ID/EX registers.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Branch_Control  in  2  redirect select:
  - 00: sequential.
  - 01: currPC_Add_Imm.
  - 10: {ALU_Result[31:1],1'b0}.
  - 11: treated as 00.
- Redirect_Valid  in  1  EX has resolved control flow this cycle; qualifies Branch_Control.
- currPC_Add_Imm  in  32  branch/JAL target.
- ALU_Result  in  32  JALR target (bit 0 ignored).
- Stall  in  1  decode cannot accept the buffered instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals PC register.
- imem_ack  in  1  response valid; may coincide with imem_req (zero-wait).
- imem_rdata  in  32  instruction word, valid with imem_ack.
- inst_valid  out  1  output buffer holds an instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  32  address of buffered instruction.
- Flush  out  1  registered one-cycle pulse after an effective redirect.

## Operation
- States:
  - FETCH: no request outstanding.
  - WAIT: request outstanding.
  - DRAIN: request outstanding, response to be discarded.
- Effective redirect: Redirect_Valid=1 and Branch_Control is 01 or 10.
  - Target = currPC_Add_Imm for 01, {ALU_Result[31:1],0} for 10.
  - Target bit 1 is not checked.
- slot_free = !inst_valid | !Stall. A buffered instruction is consumed on any cycle with inst_valid=1 and Stall=0.
- imem_req:
  - FETCH: equals slot_free.
  - WAIT and DRAIN: 1.
  - Forced to 0 while rst=1.
- imem_addr = PC in all states. The address is held stable from request until ack.
- FETCH, no redirect:
  - req & ack: inst<=imem_rdata, inst_pc<=PC, inst_valid<=1, PC<=PC+4, stay in FETCH.
  - req & !ack: go to WAIT.
  - !req: hold all state.
  - A consumed slot with no new capture clears inst_valid.
- WAIT, no redirect:
  - On ack: capture exactly as in FETCH, then go to FETCH. The slot is always empty here because the request was issued only when the slot was free.
- Redirect, in any state:
  - inst_valid<=0 and Flush<=1 on the next cycle.
  - Redirect overrides Stall.
  - FETCH, or WAIT/DRAIN with ack this cycle: any acked data is discarded, PC<=target, next state FETCH.
  - WAIT/DRAIN without ack: pend_pc<=target, go to DRAIN. PC is unchanged so imem_addr stays stable.
- DRAIN:
  - On ack: discard data, PC<=pend_pc, go to FETCH.
  - A further redirect overwrites pend_pc; the latest redirect wins.
- Redirect with Branch_Control 00/11: no effect. Flush stays 0.
- PC+4 wraps modulo 2^32.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, pend_pc=0, inst=0, inst_pc=0, inst_valid=0, Flush=0.
- imem_req rises in the first cycle with rst=0.
- Reset asserted mid-request: state is abandoned and the late ack is ignored. The memory must tolerate request withdrawal on reset.
- Zero-wait memory, no stall: one instruction per cycle. inst_valid rises the cycle after ack.
- N-cycle ack latency: inst_valid rises the cycle after ack. Next request issues the cycle after capture, or in the same cycle as consumption when the slot frees.
- Redirect with no outstanding request:
  - Cycle t: Redirect_Valid.
  - Cycle t+1: imem_addr=target and Flush=1.
- Redirect with outstanding request: target is requested the cycle after the pending ack.
- Flush is high exactly one cycle per effective redirect. Consecutive redirect cycles give consecutive Flush cycles.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, Stall=0:
  - imem_addr sequence 0,4,8,C.
  - inst_pc lags one cycle.
  - inst_valid continuously 1 from cycle 2.
- Stall=1 for 3 cycles with inst_valid=1:
  - inst and inst_pc held.
  - imem_req=0 throughout.
  - Fetch resumes the cycle Stall drops; no instruction lost or duplicated.
- Branch_Control=01, currPC_Add_Imm=0x100, Redirect_Valid=1 at PC=0x10:
  - Next cycle imem_addr=0x100, Flush=1, inst_valid=0.
- Branch_Control=10, ALU_Result=0x203:
  - Redirect target 0x202.
  - Branch_Control=11 with Redirect_Valid=1 leaves the sequence unchanged and Flush=0.
- 3-cycle ack latency, redirect to 0x40 one cycle after request at 0x8:
  - imem_addr stays 0x8 until ack.
  - Its data is never presented on inst.
  - Next request is to 0x40.
- PC=0xFFFF_FFFC sequential fetch: next imem_addr=0x0.
- rst asserted during WAIT: all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage controller; owns the PC, issues imem req/ack fetches, buffers one instruction for decode.
// Latency: inst_valid rises the cycle after imem_ack; a redirect puts the target on imem_addr (and Flush high) the next cycle.
// Backpressure: Stall holds the buffered instruction; a new fetch issues only when the buffer is empty or being consumed.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   Branch_Control, Redirect_Valid redirect select and its qualifier from EX
//   currPC_Add_Imm, ALU_Result    branch/JAL target and JALR target (bit 0 ignored)
//   Stall                         decode cannot take the buffered instruction
//   imem_req/addr/ack/rdata       instruction memory handshake (ack may be zero-wait)
//   inst_valid, inst, inst_pc     one-entry output buffer toward decode
//   Flush                         registered one-cycle pulse after an effective redirect
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Branch_Control,
  input  logic        Redirect_Valid,
  input  logic [31:0] currPC_Add_Imm,
  input  logic [31:0] ALU_Result,
  input  logic        Stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        Flush
);

  localparam logic [1:0] S_FETCH = 2'd0;  // no request outstanding
  localparam logic [1:0] S_WAIT  = 2'd1;  // request outstanding, data wanted
  localparam logic [1:0] S_DRAIN = 2'd2;  // request outstanding, data to be dropped

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_flush;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_slot_free;
  logic        w_req;
  logic        w_capture;
  logic        w_unused_alu_bit0;

  assign w_unused_alu_bit0 = ALU_Result[0];

  always_comb begin
    w_redirect  = Redirect_Valid && (Branch_Control == 2'b01 || Branch_Control == 2'b10);
    w_target    = (Branch_Control == 2'b01) ? currPC_Add_Imm : {ALU_Result[31:1], 1'b0};
    w_slot_free = !r_inst_valid || !Stall;
    w_req       = 1'b0;
    if (!rst) begin
      // Once a request is out it stays asserted until ack so the address is held.
      w_req = (r_state == S_FETCH) ? w_slot_free : 1'b1;
    end
    // WAIT never needs the slot check: its request was only issued into a free slot.
    w_capture = !w_redirect && imem_ack &&
                ((r_state == S_FETCH && w_req) || r_state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_pend_pc    <= 32'h0;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_inst_valid <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_flush <= w_redirect;
      if (w_capture) begin
        r_inst       <= imem_rdata;
        r_inst_pc    <= r_pc;
        r_inst_valid <= 1'b1;
        r_pc         <= r_pc + 32'd4;
        r_state      <= S_FETCH;
      end else if (w_redirect) begin
        r_inst_valid <= 1'b0;
        if (r_state == S_FETCH || imem_ack) begin
          // Nothing left in flight (or it completes now and is dropped).
          r_pc    <= w_target;
          r_state <= S_FETCH;
        end else begin
          // Keep PC (and so imem_addr) stable until the old request acks.
          r_pend_pc <= w_target;
          r_state   <= S_DRAIN;
        end
      end else begin
        if (r_inst_valid && !Stall) begin
          r_inst_valid <= 1'b0;
        end
        case (r_state)
          S_FETCH: begin
            if (w_req) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            r_state <= S_WAIT;
          end
          S_DRAIN: begin
            if (imem_ack) begin
              r_pc    <= r_pend_pc;
              r_state <= S_FETCH;
            end
          end
          default: begin
            r_state <= S_FETCH;
          end
        endcase
      end
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign Flush      = r_flush;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized and directed bench for pc_fetch_ctrl against a behavioural fetch model.
// Latency: memory responder acks a configurable number of cycles after a request is seen.
// Backpressure: Stall driven directly by the scenarios.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Branch_Control;
  logic        Redirect_Valid;
  logic [31:0] currPC_Add_Imm;
  logic [31:0] ALU_Result;
  logic        Stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        Flush;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .Branch_Control(Branch_Control),
    .Redirect_Valid(Redirect_Valid),
    .currPC_Add_Imm(currPC_Add_Imm),
    .ALU_Result    (ALU_Result),
    .Stall         (Stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .Flush         (Flush)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K = 32'hA5A5_0000;

  int errors = 0;
  int checks = 0;

  // Memory responder: one request at a time, data = addr ^ K, ack lat cycles after first seen.
  int          lat = 0;
  bit          mbusy = 0;
  int          mcnt = 0;
  logic [31:0] maddr = 32'h0;

  // Behavioural model of the fetch stage.
  logic [31:0] m_pc = 32'h0, m_inst = 32'h0, m_ipc = 32'h0, m_pend = 32'h0;
  bit          m_vld = 0, m_out = 0, m_drop = 0, m_flush = 0;

  function automatic bit m_req();
    return !rst && (m_out || !m_vld || !Stall);
  endfunction

  function automatic logic [98:0] exp_vec();
    return {m_req(), m_pc, m_vld, m_inst, m_ipc, m_flush};
  endfunction

  function automatic logic [98:0] dut_vec();
    return {imem_req, imem_addr, inst_valid, inst, inst_pc, Flush};
  endfunction

  task automatic m_capture();
    m_inst = m_pc ^ K;
    m_ipc  = m_pc;
    m_vld  = 1;
    m_pc   = m_pc + 32'd4;
  endtask

  task automatic model_step();
    bit          eff;
    bit          req;
    bit          cons;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_pend = 32'h0;
      m_vld = 0; m_out = 0; m_drop = 0; m_flush = 0;
    end else begin
      eff  = Redirect_Valid && (Branch_Control == 2'b01 || Branch_Control == 2'b10);
      tgt  = (Branch_Control == 2'b01) ? currPC_Add_Imm : (ALU_Result & 32'hFFFF_FFFE);
      req  = m_req();
      cons = m_vld && !Stall;
      m_flush = eff;
      if (eff) begin
        m_vld = 0;
        if (!m_out || imem_ack) begin
          m_pc = tgt; m_out = 0; m_drop = 0;
        end else begin
          m_pend = tgt; m_out = 1; m_drop = 1;
        end
      end else if (!m_out) begin
        if (req && imem_ack) m_capture();
        else begin
          if (req) m_out = 1;
          if (cons) m_vld = 0;
        end
      end else if (imem_ack) begin
        if (m_drop) m_pc = m_pend;
        else m_capture();
        m_out = 0; m_drop = 0;
      end else if (cons) begin
        m_vld = 0;
      end
    end
  endtask

  task automatic mem_eval();
    if (!imem_req) begin
      mbusy    = 0;
      imem_ack = 1'b0;
    end else begin
      if (!mbusy || imem_addr !== maddr) begin
        mbusy = 1; maddr = imem_addr; mcnt = lat;
      end
      imem_ack   = (mcnt == 0);
      imem_rdata = maddr ^ K;
    end
  endtask

  task automatic mem_post();
    if (imem_ack) mbusy = 0;
    else if (mbusy && mcnt > 0) mcnt = mcnt - 1;
    imem_ack = 1'b0;
  endtask

  task automatic settle();
    #1; mem_eval(); #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk); #1;
    mem_post();
  endtask

  task automatic idle_inputs();
    Redirect_Valid = 1'b0; Branch_Control = 2'b00; Stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); currPC_Add_Imm = 32'h0; ALU_Result = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; lat = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    rst = 1'b0; lat = 0; idle_inputs();
    for (int k = 0; k < 6; k++) begin
      settle();
      e = 32'(4 * k);
      checks++;
      if (imem_addr !== e) begin
        errors++; $display("FAIL seq_addr k=%0d: got %h expected %h", k, imem_addr, e);
      end
      checks++;
      if (inst_valid !== (k >= 1)) begin
        errors++; $display("FAIL seq_valid k=%0d: got %b expected %b", k, inst_valid, (k >= 1));
      end
      if (k >= 1) begin
        e = 32'(4 * (k - 1));
        checks++;
        if (inst_pc !== e) begin
          errors++; $display("FAIL seq_inst_pc k=%0d: got %h expected %h", k, inst_pc, e);
        end
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL seq_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_inst;
    held_pc = m_ipc; held_inst = m_inst;
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (imem_req !== 1'b0 || inst_pc !== held_pc || inst !== held_inst || inst_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold k=%0d: got req=%b pc=%h inst=%h v=%b expected req=0 pc=%h inst=%h v=1",
                 k, imem_req, inst_pc, inst, inst_valid, held_pc, held_inst);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      advance();
    end
    Stall = 1'b0;
    settle();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL stall_resume_req: got %b expected 1", imem_req);
    end
    advance();
    settle();
    checks++;
    if (inst_pc !== held_pc + 32'd4 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL stall_next_inst: got pc=%h v=%b expected pc=%h v=1", inst_pc, inst_valid, held_pc + 32'd4);
    end
    advance();
  endtask

  task automatic test_redirect_imm();
    bit done = 0;
    rst = 1'b1; idle_inputs(); lat = 0;
    settle(); advance();
    rst = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (m_pc == 32'h10) begin
        Redirect_Valid = 1'b1; Branch_Control = 2'b01; currPC_Add_Imm = 32'h100; done = 1;
      end
      settle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL imm_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      advance();
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL imm_reach_pc: got no cycle at pc 10 expected one within 20 cycles");
    end
    idle_inputs();
    settle();
    checks++;
    if (imem_addr !== 32'h100 || Flush !== 1'b1 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL imm_redirect: got addr=%h flush=%b v=%b expected addr=100 flush=1 v=0", imem_addr, Flush, inst_valid);
    end
    advance();
  endtask

  task automatic test_jalr();
    logic [31:0] prev;
    Redirect_Valid = 1'b1; Branch_Control = 2'b10; ALU_Result = 32'h203;
    settle(); advance();
    idle_inputs();
    settle();
    checks++;
    if (imem_addr !== 32'h202 || Flush !== 1'b1) begin
      errors++; $display("FAIL jalr_target: got addr=%h flush=%b expected addr=202 flush=1", imem_addr, Flush);
    end
    advance();
    settle(); advance();
    prev = m_pc;
    Redirect_Valid = 1'b1; Branch_Control = 2'b11; currPC_Add_Imm = 32'h500;
    settle(); advance();
    idle_inputs();
    settle();
    checks++;
    if (imem_addr !== prev + 32'd4 || Flush !== 1'b0) begin
      errors++; $display("FAIL bc11_noop: got addr=%h flush=%b expected addr=%h flush=0", imem_addr, Flush, prev + 32'd4);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL jalr_model: got %h expected %h", dut_vec(), exp_vec());
    end
    advance();
  endtask

  task automatic test_latency();
    bit found = 0;
    bit acked = 0;
    rst = 1'b1; idle_inputs(); lat = 3;
    settle(); advance();
    rst = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      settle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lat_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      if (m_pc == 32'h8 && !m_out && m_req()) found = 1;
      advance();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL lat_reach_8: got no request at 8 expected one within 30 cycles");
    end
    Redirect_Valid = 1'b1; Branch_Control = 2'b01; currPC_Add_Imm = 32'h40;
    settle();
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++; $display("FAIL lat_addr_redirect: got %h expected 8", imem_addr);
    end
    advance();
    idle_inputs();
    for (int k = 0; k < 10 && !acked; k++) begin
      settle();
      acked = imem_ack;
      checks++;
      if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
        errors++; $display("FAIL lat_addr_hold k=%0d: got addr=%h req=%b expected addr=8 req=1", k, imem_addr, imem_req);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lat_drain_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      advance();
    end
    checks++;
    if (!acked) begin
      errors++; $display("FAIL lat_ack_timeout: got no ack expected one within 10 cycles");
    end
    for (int k = 0; k < 4; k++) begin
      settle();
      if (k == 0) begin
        checks++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
          errors++; $display("FAIL lat_next_req: got addr=%h req=%b expected addr=40 req=1", imem_addr, imem_req);
        end
      end
      checks++;
      if (inst_valid === 1'b1 && (inst_pc === 32'h8 || inst === (32'h8 ^ K))) begin
        errors++; $display("FAIL lat_stale_data k=%0d: got inst_pc=%h inst=%h expected not the dropped fetch", k, inst_pc, inst);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    lat = 0; Stall = 1'b0;
    Redirect_Valid = 1'b1; Branch_Control = 2'b01; currPC_Add_Imm = 32'hFFFF_FFFC;
    settle(); advance();
    idle_inputs();
    for (int k = 0; k < 6 && m_pc != 32'hFFFF_FFFC; k++) begin
      settle(); advance();
    end
    settle();
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_start: got %h expected fffffffc", imem_addr);
    end
    advance();
    settle();
    checks++;
    if (imem_addr !== 32'h0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrap_next: got %h expected %h", dut_vec(), exp_vec());
    end
    advance();
  endtask

  task automatic test_reset_wait();
    lat = 3; idle_inputs();
    for (int k = 0; k < 10 && !m_out; k++) begin
      settle(); advance();
    end
    checks++;
    if (!m_out) begin
      errors++; $display("FAIL rstw_reach_wait: got no outstanding request expected one within 10 cycles");
    end
    rst = 1'b1;
    settle();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rstw_req_drop: got %b expected 0", imem_req);
    end
    advance();
    settle();
    checks++;
    if (dut_vec() !== 99'h0) begin
      errors++; $display("FAIL rstw_outputs: got %h expected 0", dut_vec());
    end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      lat = seg;
      for (int k = 0; k < 150; k++) begin
        rst            = ($urandom_range(0, 99) == 0);
        Stall          = ($urandom_range(0, 3) == 0);
        Redirect_Valid = ($urandom_range(0, 5) == 0);
        Branch_Control = 2'($urandom_range(0, 3));
        currPC_Add_Imm = $urandom & 32'hFFFF_FFFC;
        ALU_Result     = $urandom;
        settle();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL rand_model lat=%0d k=%0d: got %h expected %h", seg, k, dut_vec(), exp_vec());
        end
        advance();
      end
    end
    rst = 1'b0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_imm();
    test_jalr();
    test_latency();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
